// File: rtl/fft_pkg.sv
// Shared FFT sequencer definitions: FSM state encoding, default butterfly latency,
// and a bit-reverse helper for preparing input sample order.
package fft_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    RUN,
    DRAIN,
    DONE
  } fsm_state_t;

  localparam int BF_LAT_DEF = 3;

  // Reverse the low 'bits' bits of v (bits <= 12); upper bits return as zero.
  function automatic logic [11:0] bit_rev(input logic [11:0] v, input int bits);
    logic [11:0] r;
    r = '0;
    for (int i = 0; i < 12; i++) begin
      if (i < bits) r[bits-1-i] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational radix-2 DIT address generator: maps (stage, butterfly index) to the
// in-place lo/hi sample addresses and the twiddle ROM address.
module fft_addr_gen #(
  parameter int LOG2N = 6,
  parameter int SW    = 3
) (
  input  logic [SW-1:0]    stage,
  input  logic [LOG2N-2:0] bfly,
  output logic [LOG2N-1:0] lo,
  output logic [LOG2N-1:0] hi,
  output logic [LOG2N-2:0] tw
);

  localparam int TW_W = LOG2N - 1;

  logic [LOG2N-1:0] jw;
  logic [LOG2N-1:0] span;
  logic [LOG2N-1:0] low;

  always_comb begin
    jw   = LOG2N'(bfly);
    span = LOG2N'(1) << stage;
    low  = jw & (span - LOG2N'(1));
    // Insert a zero at bit 'stage' of j: that bit selects lo vs hi of the pair.
    lo   = (((jw >> stage) << 1) << stage) | low;
    hi   = lo | span;
    tw   = TW_W'(low << (LOG2N - 1 - int'(stage)));
  end

endmodule

// File: rtl/butterfly_sched.sv
// In-place radix-2 DIT FFT sequencer driving one shared 2-cycle butterfly.
// Optional build macro BFLY_SCHED_PERF_EN adds a 16-bit busy-cycle counter port.
module butterfly_sched
  import fft_pkg::*;
#(
  parameter int LOG2N  = 6,
  parameter int BF_LAT = BF_LAT_DEF,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             bf_rst,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [LOG2N-2:0] tw_addr,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b
`ifdef BFLY_SCHED_PERF_EN
  ,
  output logic [15:0]      cycle_cnt
`endif
);

  localparam int SW        = $clog2(LOG2N);
  localparam int JW        = LOG2N - 1;
  localparam int DRAIN_LEN = BF_LAT + 2;
  localparam int DW        = $clog2(DRAIN_LEN);
  // Edges from an address update to the matching write strobe: RAM read, butterfly, output reg.
  localparam int WB_DLY    = RD_LAT + BF_LAT + 1;

  localparam logic [JW-1:0] JLAST = '1;
  localparam logic [SW-1:0] SLAST = SW'(LOG2N - 1);
  localparam logic [DW-1:0] DLAST = DW'(DRAIN_LEN - 1);

  typedef struct packed {
    logic             v;
    logic [LOG2N-1:0] lo;
    logic [LOG2N-1:0] hi;
  } wb_t;

  fsm_state_t    state, state_nxt;
  logic [SW-1:0] stage, stage_nxt;
  logic [JW-1:0] bfly, bfly_nxt;
  logic [DW-1:0] dcnt, dcnt_nxt;
  // Which of the two issue cycles of the current butterfly we are in.
  logic          half, half_nxt;
  logic          load;
  logic          iss;

  logic [LOG2N-1:0] gen_lo, gen_hi;
  logic [LOG2N-2:0] gen_tw;

  wb_t wb_pipe [WB_DLY];

  fft_addr_gen #(
    .LOG2N (LOG2N),
    .SW    (SW)
  ) u_addr_gen (
    .stage (stage_nxt),
    .bfly  (bfly_nxt),
    .lo    (gen_lo),
    .hi    (gen_hi),
    .tw    (gen_tw)
  );

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    stage_nxt = stage;
    bfly_nxt  = bfly;
    dcnt_nxt  = dcnt;
    half_nxt  = half;
    load      = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ALIGN;
          stage_nxt = '0;
          bfly_nxt  = '0;
        end
      end
      ALIGN: begin
        state_nxt = RUN;
        half_nxt  = 1'b0;
        load      = 1'b1;
      end
      RUN: begin
        half_nxt = ~half;
        if (half) begin
          if (bfly == JLAST) begin
            state_nxt = DRAIN;
            dcnt_nxt  = '0;
          end else begin
            bfly_nxt = bfly + JW'(1);
            load     = 1'b1;
          end
        end
      end
      DRAIN: begin
        // Fixed wait so the last in-place write of this stage lands before the next stage reads.
        dcnt_nxt = dcnt + DW'(1);
        if (dcnt == DLAST) begin
          if (stage == SLAST) begin
            state_nxt = DONE;
          end else begin
            state_nxt = RUN;
            stage_nxt = stage + SW'(1);
            bfly_nxt  = '0;
            half_nxt  = 1'b0;
            load      = 1'b1;
          end
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      stage     <= '0;
      bfly      <= '0;
      dcnt      <= '0;
      half      <= 1'b0;
      iss       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bf_rst    <= 1'b1;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
    end else begin
      state  <= state_nxt;
      stage  <= stage_nxt;
      bfly   <= bfly_nxt;
      dcnt   <= dcnt_nxt;
      half   <= half_nxt;
      iss    <= load;
      busy   <= (state_nxt != IDLE);
      done   <= (state_nxt == DONE);
      bf_rst <= (state_nxt == IDLE);
      if (load) begin
        rd_addr_a <= gen_lo;
        rd_addr_b <= gen_hi;
        tw_addr   <= gen_tw;
      end
    end
  end

  // Write-back delay line carrying each butterfly's (lo, hi) pair to its write strobe.
  // NOTE: the delay line is reset too, so an aborted run cannot emit a stale write strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WB_DLY; i++) wb_pipe[i] <= '0;
    end else begin
      wb_pipe[0] <= '{v: iss, lo: rd_addr_a, hi: rd_addr_b};
      for (int i = 1; i < WB_DLY; i++) wb_pipe[i] <= wb_pipe[i-1];
    end
  end

  assign wr_en     = wb_pipe[WB_DLY-1].v;
  assign wr_addr_a = wb_pipe[WB_DLY-1].lo;
  assign wr_addr_b = wb_pipe[WB_DLY-1].hi;

`ifdef BFLY_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt <= '0;
    end else if ((state == IDLE) && start) begin
      cycle_cnt <= '0;
    end else if (busy) begin
      cycle_cnt <= cycle_cnt + 16'd1;
    end
  end
`endif

endmodule
